// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Counter state encodings, default widths, entry layout, PC field extraction.
package btb_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int BTB_PC_W    = 32;
    localparam int BTB_INDEX_W = 4;
    localparam int BTB_TAG_W   = BTB_PC_W - BTB_INDEX_W - 2;

    // Layout of one entry at the default geometry.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-1:0]  target;
        logic [1:0]           ctr;
    } btb_entry_t;

    // Word-aligned index: pc[iw+1:2]. Caller truncates to its index width.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc,
                                           input int unsigned  iw);
        return (pc >> 2) & ((64'd1 << iw) - 64'd1);
    endfunction

    // Tag: everything above the index. Caller truncates to its tag width.
    function automatic logic [63:0] pc_tag(input logic [63:0] pc,
                                           input int unsigned  iw);
        return pc >> (iw + 2);
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
// Ports: ctr_i current state, taken_i resolved direction, ctr_o next state.
module sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (1'b1)
            taken_i && ctr_i != ST:  ctr_o = ctr_i + 2'd1;
            !taken_i && ctr_i != SNT: ctr_o = ctr_i - 2'd1;
            default:                 ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup for IF,
// EX-stage resolve (flush/hit/redirect), table update and mispredict count.
// Ports: clk/rst; if_pc -> pred_hit/pred_target; ex_* resolve inputs ->
// flush/hit/redirect_pc; mispredict_cnt statistics.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_hit,
    output logic [PC_W-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_hit,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic             flush,
    output logic             hit,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int TAG_W = PC_W - INDEX_W - 2;
    localparam int N     = 1 << INDEX_W;

    logic [N-1:0]      valid_q;
    logic [TAG_W-1:0]  tag_q [N];
    logic [PC_W-1:0]   tgt_q [N];
    logic [1:0]        ctr_q [N];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [INDEX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]   if_tag, ex_tag;
    logic               br, match, mispredict;
    logic [1:0]         ctr_d;

    assign if_idx = INDEX_W'(pc_idx(64'(if_pc), INDEX_W));
    assign if_tag = TAG_W'(pc_tag(64'(if_pc), INDEX_W));
    assign ex_idx = INDEX_W'(pc_idx(64'(ex_pc), INDEX_W));
    assign ex_tag = TAG_W'(pc_tag(64'(ex_pc), INDEX_W));

    // Lookup reads registered state only: no bypass of a same-cycle update.
    assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag)
                         && ctr_q[if_idx][1];
    assign pred_target = tgt_q[if_idx];

    assign br          = ex_valid && ex_is_branch;
    assign flush       = br && (ex_taken || ex_pred_hit);
    assign hit         = br && ex_pred_hit && ex_taken
                         && (ex_pred_target == ex_target);
    assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

    assign mispredict = br && ((ex_taken != ex_pred_hit)
                        || (ex_taken && ex_pred_hit
                            && (ex_pred_target != ex_target)));

    assign match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign cnt_d = cnt_q + CNT_W'(mispredict);

    sat_counter2 u_ctr (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (ex_taken),
        .ctr_o   (ctr_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) ctr_q[i] <= WNT;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (br) begin
                if (match) begin
                    ctr_q[ex_idx] <= ctr_d;
                    if (ex_taken) tgt_q[ex_idx] <= ex_target;
                end else if (ex_taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    tgt_q[ex_idx]   <= ex_target;
                    ctr_q[ex_idx]   <= WT;
                end
            end
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed-vector bench for btb_predictor.
// Drives lookup/resolve vectors and compares against hand-computed values.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_hit;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        flush, hit;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btb_predictor #(.PC_W(32), .INDEX_W(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_hit    (ex_pred_hit),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .hit            (hit),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tg, input logic ph,
                           input logic [31:0] pt);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tg;
        ex_pred_hit    = ph;
        ex_pred_target = pt;
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        ex_valid = 1'b0;
        ex_is_branch = 1'b0;
        ex_pc = '0;
        ex_taken = 1'b0;
        ex_target = '0;
        ex_pred_hit = 1'b0;
        ex_pred_target = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_pred_hit", 32'(pred_hit), 32'd0);
        check_eq("rst_cnt", 32'(mispredict_cnt), 32'd0);

        // Cold taken branch: allocate 01 -> 10
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check_eq("cold_flush", 32'(flush), 32'd1);
        check_eq("cold_hit", 32'(hit), 32'd0);
        check_eq("cold_redir", redirect_pc, 32'h200);
        check_eq("no_bypass", 32'(pred_hit), 32'd0);
        step();
        look(32'h100);
        check_eq("alloc_hit", 32'(pred_hit), 32'd1);
        check_eq("alloc_tgt", pred_target, 32'h200);
        check_eq("cnt1", 32'(mispredict_cnt), 32'd1);

        // Correct prediction: 10 -> 11
        resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check_eq("good_flush", 32'(flush), 32'd1);
        check_eq("good_hit", 32'(hit), 32'd1);
        step();
        check_eq("good_cnt", 32'(mispredict_cnt), 32'd1);

        // Two not-taken: 11 -> 10 -> 01
        resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        check_eq("nt_flush", 32'(flush), 32'd1);
        check_eq("nt_hit", 32'(hit), 32'd0);
        check_eq("nt_redir", redirect_pc, 32'h104);
        step();
        check_eq("nt1_hit", 32'(pred_hit), 32'd1);
        resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        step();
        check_eq("nt2_hit", 32'(pred_hit), 32'd0);
        check_eq("nt_cnt", 32'(mispredict_cnt), 32'd3);

        // Still valid: one taken 01 -> 10 on match path
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        step();
        check_eq("rehit", 32'(pred_hit), 32'd1);

        // Alias 0x140 into idx 0: replace with ctr 10
        resolve(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
        step();
        look(32'h140);
        check_eq("alias_hit", 32'(pred_hit), 32'd1);
        check_eq("alias_tgt", pred_target, 32'h300);
        look(32'h100);
        check_eq("alias_old", 32'(pred_hit), 32'd0);
        resolve(32'h140, 1'b0, 32'h0, 1'b1, 32'h300);
        step();
        look(32'h140);
        check_eq("alias_ctr10", 32'(pred_hit), 32'd0);
        check_eq("alias_cnt", 32'(mispredict_cnt), 32'd6);

        // Saturation at 11
        look(32'h208);
        resolve(32'h208, 1'b1, 32'h400, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            resolve(32'h208, 1'b1, 32'h400, 1'b1, 32'h400);
            step();
        end
        resolve(32'h208, 1'b0, 32'h0, 1'b1, 32'h400);
        step();
        check_eq("sat_10", 32'(pred_hit), 32'd1);
        resolve(32'h208, 1'b0, 32'h0, 1'b1, 32'h400);
        step();
        check_eq("sat_01", 32'(pred_hit), 32'd0);
        check_eq("sat_cnt", 32'(mispredict_cnt), 32'd9);

        // Target mismatch and ex_valid gating, combinational only
        resolve(32'h208, 1'b1, 32'h500, 1'b1, 32'h400);
        check_eq("tm_flush", 32'(flush), 32'd1);
        check_eq("tm_hit", 32'(hit), 32'd0);
        ex_valid = 1'b0;
        #1;
        check_eq("inv_flush", 32'(flush), 32'd0);

        // Non-branch: no flush, no update; redirect wraps
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        ex_is_branch = 1'b0;
        ex_taken = 1'b1;
        ex_pc = 32'h300;
        ex_target = 32'h700;
        #1;
        check_eq("nb_flush", 32'(flush), 32'd0);
        ex_taken = 1'b0;
        ex_pc = 32'hFFFF_FFFC;
        #1;
        check_eq("wrap_redir", redirect_pc, 32'h0);
        ex_taken = 1'b1;
        ex_pc = 32'h300;
        #1;
        step();
        look(32'h300);
        check_eq("nb_hit", 32'(pred_hit), 32'd0);
        check_eq("nb_cnt", 32'(mispredict_cnt), 32'd9);

        // Reset on the same edge as an update
        resolve(32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        look(32'h400);
        check_eq("rstupd_hit", 32'(pred_hit), 32'd0);
        look(32'h140);
        check_eq("rst_clear", 32'(pred_hit), 32'd0);
        check_eq("rst_cnt2", 32'(mispredict_cnt), 32'd0);

        // Counter wrap: not-taken mispredicts on an invalid entry
        resolve(32'h600, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        check_eq("cnt_max", 32'(mispredict_cnt), 32'h0000_FFFF);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check_eq("cnt_wrap", 32'(mispredict_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
